// File: rtl/universal_shift_reg_if.sv
// Bus bundle for universal_shift_reg: control/data inputs driven by the master,
// register state and burst status returned by the slave (the shift register).
interface universal_shift_reg_if #(
  parameter int DW = 8,
  parameter int CW = $clog2(DW) + 1
);
  logic          load;
  logic [DW-1:0] data;
  logic          en;
  logic [1:0]    mode;
  logic          ser_in_h;
  logic          ser_in_l;
  logic          start;
  logic [CW-1:0] shift_num;
  logic [DW-1:0] q;
  logic          ser_out;
  logic          busy;
  logic          done;

  modport master (
    output load, data, en, mode, ser_in_h, ser_in_l, start, shift_num,
    input  q, ser_out, busy, done
  );

  modport slave (
    input  load, data, en, mode, ser_in_h, ser_in_l, start, shift_num,
    output q, ser_out, busy, done
  );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal shift register with left/right shift, serial in/out and a self-timed
// burst engine. Define USR_ROTATE_EN to make mode 11 rotate right (else it holds).
module universal_shift_reg #(
  parameter int DW = 8,
  parameter int CW = $clog2(DW) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sync_rst,
  universal_shift_reg_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic          done_q, done_d;
  logic [1:0]    eff_mode_s;
  logic          ser_out_s;

  function automatic logic [DW-1:0] shift_fn(
    input logic [1:0]    m,
    input logic [DW-1:0] v,
    input logic          si_h,
    input logic          si_l
  );
    logic [DW-1:0] r;
    case (m)
      2'b01:   r = {si_h, v[DW-1:1]};
      2'b10:   r = {v[DW-2:0], si_l};
`ifdef USR_ROTATE_EN
      2'b11:   r = {v[0], v[DW-1:1]};
`else
      2'b11:   r = v;
`endif
      default: r = v;
    endcase
    return r;
  endfunction

  // Next-state: priority sync_rst > load > burst step > start > single step
  always_comb begin
    sr_d    = sr_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    if (sync_rst) begin
      sr_d    = {DW{1'b0}};
      state_d = IDLE;
      cnt_d   = {CW{1'b0}};
      mode_d  = 2'b00;
    end else if (bus.load) begin
      sr_d    = bus.data;
      state_d = IDLE;
      cnt_d   = {CW{1'b0}};
    end else if (state_q == RUN) begin
      sr_d  = shift_fn(mode_q, sr_q, bus.ser_in_h, bus.ser_in_l);
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (bus.start) begin
      // A zero-length burst never enters RUN but still reports completion
      if (bus.shift_num != {CW{1'b0}}) begin
        state_d = RUN;
        cnt_d   = bus.shift_num;
        mode_d  = bus.mode;
      end else begin
        done_d = 1'b1;
      end
    end else if (bus.en) begin
      sr_d = shift_fn(bus.mode, sr_q, bus.ser_in_h, bus.ser_in_l);
    end else begin
      sr_d = sr_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= {DW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      mode_q  <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  // Serial out shows the bit the next shift would discard
  always_comb begin
    eff_mode_s = (state_q == RUN) ? mode_q : bus.mode;
    case (eff_mode_s)
      2'b01:   ser_out_s = sr_q[0];
      2'b10:   ser_out_s = sr_q[DW-1];
`ifdef USR_ROTATE_EN
      2'b11:   ser_out_s = sr_q[0];
`else
      2'b11:   ser_out_s = 1'b0;
`endif
      default: ser_out_s = 1'b0;
    endcase
  end

  assign bus.q       = sr_q;
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = done_q;
  assign bus.ser_out = ser_out_s;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed table-driven bench for universal_shift_reg (DW=8), plus a hand-written
// asynchronous-reset sequence.
module tb_universal_shift_reg;

  localparam int DW = 8;
  localparam int CW = 4;

  logic clk;
  logic rst_n;
  logic sync_rst;

  universal_shift_reg_if #(.DW(DW), .CW(CW)) bus ();

  universal_shift_reg #(.DW(DW), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_rst (sync_rst),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          srst;
    logic          ld;
    logic [DW-1:0] data;
    logic          en;
    logic [1:0]    mode;
    logic          sih;
    logic          sil;
    logic          start;
    logic [CW-1:0] num;
    logic          exp_so;
    logic [DW-1:0] exp_q;
    logic          exp_busy;
    logic          exp_done;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  task automatic add(input logic srst, input logic ld, input logic [7:0] data,
                     input logic en, input logic [1:0] mode, input logic sih,
                     input logic sil, input logic start, input logic [3:0] num,
                     input logic exp_so, input logic [7:0] exp_q,
                     input logic exp_busy, input logic exp_done);
    vec_t v;
    v.srst = srst; v.ld = ld; v.data = data; v.en = en; v.mode = mode;
    v.sih = sih; v.sil = sil; v.start = start; v.num = num;
    v.exp_so = exp_so; v.exp_q = exp_q; v.exp_busy = exp_busy; v.exp_done = exp_done;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    sync_rst      = 1'b0;
    bus.load      = 1'b0;
    bus.data      = 8'h00;
    bus.en        = 1'b0;
    bus.mode      = 2'b00;
    bus.ser_in_h  = 1'b0;
    bus.ser_in_l  = 1'b0;
    bus.start     = 1'b0;
    bus.shift_num = 4'd0;
  endtask

  initial begin
    logic [7:0] rq;
    logic [7:0] prev_q;
    logic       rot_so;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive_idle();

    // Fill the vector table
    add(1'b0,1'b1,8'hA5,1'b0,2'b00,1'b0,1'b0,1'b0,4'd0, 1'b0,8'hA5,1'b0,1'b0);
    add(1'b0,1'b0,8'h00,1'b1,2'b01,1'b1,1'b0,1'b0,4'd0, 1'b1,8'hD2,1'b0,1'b0);
    add(1'b0,1'b0,8'h00,1'b1,2'b10,1'b0,1'b1,1'b0,4'd0, 1'b1,8'hA5,1'b0,1'b0);
    add(1'b0,1'b0,8'h00,1'b1,2'b00,1'b1,1'b1,1'b0,4'd0, 1'b0,8'hA5,1'b0,1'b0);
    // left burst of 3 from 0x81
    add(1'b0,1'b1,8'h81,1'b0,2'b00,1'b0,1'b0,1'b0,4'd0, 1'b0,8'h81,1'b0,1'b0);
    add(1'b0,1'b0,8'h00,1'b0,2'b10,1'b0,1'b0,1'b1,4'd3, 1'b1,8'h81,1'b1,1'b0);
    add(1'b0,1'b0,8'h00,1'b0,2'b00,1'b0,1'b0,1'b0,4'd0, 1'b1,8'h02,1'b1,1'b0);
    add(1'b0,1'b0,8'h00,1'b0,2'b00,1'b0,1'b0,1'b0,4'd0, 1'b0,8'h04,1'b1,1'b0);
    add(1'b0,1'b0,8'h00,1'b0,2'b00,1'b0,1'b0,1'b0,4'd0, 1'b0,8'h08,1'b0,1'b1);
    add(1'b0,1'b0,8'h00,1'b0,2'b00,1'b0,1'b0,1'b0,4'd0, 1'b0,8'h08,1'b0,1'b0);
    // zero-length burst
    add(1'b0,1'b1,8'h77,1'b0,2'b00,1'b0,1'b0,1'b0,4'd0, 1'b0,8'h77,1'b0,1'b0);
    add(1'b0,1'b0,8'h00,1'b0,2'b01,1'b0,1'b0,1'b1,4'd0, 1'b1,8'h77,1'b0,1'b1);
    add(1'b0,1'b0,8'h00,1'b0,2'b00,1'b0,1'b0,1'b0,4'd0, 1'b0,8'h77,1'b0,1'b0);
    // rotate burst of 8 from 0x01 (holds when rotate is compiled out)
`ifdef USR_ROTATE_EN
    rot_so = 1'b1;
`else
    rot_so = 1'b0;
`endif
    add(1'b0,1'b1,8'h01,1'b0,2'b00,1'b0,1'b0,1'b0,4'd0, 1'b0,8'h01,1'b0,1'b0);
    add(1'b0,1'b0,8'h00,1'b0,2'b11,1'b0,1'b0,1'b1,4'd8, rot_so,8'h01,1'b1,1'b0);
    prev_q = 8'h01;
    for (int k = 1; k <= 8; k++) begin
`ifdef USR_ROTATE_EN
      rq     = 8'h01;
      rq     = (rq >> k) | (rq << (8 - k));
      rot_so = prev_q[0];
`else
      rq     = 8'h01;
      rot_so = 1'b0;
`endif
      add(1'b0,1'b0,8'h00,1'b0,2'b00,1'b0,1'b0,1'b0,4'd0,
          rot_so, rq, (k < 8), (k == 8));
      prev_q = rq;
    end
    // sync_rst abort while streaming ser_in_h=1 to the right
    add(1'b0,1'b1,8'hF0,1'b0,2'b00,1'b0,1'b0,1'b0,4'd0, 1'b0,8'hF0,1'b0,1'b0);
    add(1'b0,1'b0,8'h00,1'b0,2'b01,1'b1,1'b0,1'b1,4'd5, 1'b0,8'hF0,1'b1,1'b0);
    add(1'b0,1'b0,8'h00,1'b0,2'b00,1'b1,1'b0,1'b0,4'd0, 1'b0,8'hF8,1'b1,1'b0);
    add(1'b1,1'b0,8'h00,1'b0,2'b00,1'b1,1'b0,1'b0,4'd0, 1'b0,8'h00,1'b0,1'b0);
    add(1'b0,1'b0,8'h00,1'b0,2'b00,1'b0,1'b0,1'b0,4'd0, 1'b0,8'h00,1'b0,1'b0);
    // load abort, with start during RUN and alongside load ignored
    add(1'b0,1'b0,8'h00,1'b0,2'b01,1'b0,1'b0,1'b1,4'd5, 1'b0,8'h00,1'b1,1'b0);
    add(1'b0,1'b0,8'h00,1'b0,2'b10,1'b0,1'b1,1'b1,4'd2, 1'b0,8'h00,1'b1,1'b0);
    add(1'b0,1'b1,8'h3C,1'b0,2'b00,1'b0,1'b0,1'b1,4'd2, 1'b0,8'h3C,1'b0,1'b0);
    add(1'b0,1'b0,8'h00,1'b0,2'b00,1'b0,1'b0,1'b0,4'd0, 1'b0,8'h3C,1'b0,1'b0);
    // start during RUN is ignored; next start accepted right after EN
    add(1'b0,1'b0,8'h00,1'b0,2'b01,1'b0,1'b0,1'b1,4'd2, 1'b0,8'h3C,1'b1,1'b0);
    add(1'b0,1'b0,8'h00,1'b0,2'b10,1'b0,1'b1,1'b1,4'd5, 1'b0,8'h1E,1'b1,1'b0);
    add(1'b0,1'b0,8'h00,1'b0,2'b00,1'b0,1'b0,1'b0,4'd0, 1'b0,8'h0F,1'b0,1'b1);
    add(1'b0,1'b0,8'h00,1'b0,2'b01,1'b1,1'b0,1'b1,4'd1, 1'b1,8'h0F,1'b1,1'b0);
    add(1'b0,1'b0,8'h00,1'b0,2'b00,1'b0,1'b0,1'b0,4'd0, 1'b1,8'h07,1'b0,1'b1);
    add(1'b0,1'b0,8'h00,1'b0,2'b00,1'b0,1'b0,1'b0,4'd0, 1'b0,8'h07,1'b0,1'b0);

    // Reset state
    #12;
    chk("rst_q",    bus.q,       8'h00);
    chk("rst_busy", bus.busy,    1'b0);
    chk("rst_done", bus.done,    1'b0);
    chk("rst_so",   bus.ser_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      sync_rst      = vecs[i].srst;
      bus.load      = vecs[i].ld;
      bus.data      = vecs[i].data;
      bus.en        = vecs[i].en;
      bus.mode      = vecs[i].mode;
      bus.ser_in_h  = vecs[i].sih;
      bus.ser_in_l  = vecs[i].sil;
      bus.start     = vecs[i].start;
      bus.shift_num = vecs[i].num;
      #1;
      chk($sformatf("v%0d_so", i), bus.ser_out, vecs[i].exp_so);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_q", i),    bus.q,    vecs[i].exp_q);
      chk($sformatf("v%0d_busy", i), bus.busy, vecs[i].exp_busy);
      chk($sformatf("v%0d_done", i), bus.done, vecs[i].exp_done);
    end

    // Asynchronous reset mid-cycle while done is high
    @(negedge clk);
    drive_idle();
    bus.load = 1'b1;
    bus.data = 8'h5A;
    @(negedge clk);
    drive_idle();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_pre_q",    bus.q,    8'h5A);
    chk("arst_pre_done", bus.done, 1'b1);
    drive_idle();
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_q",    bus.q,    8'h00);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_done", bus.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_hold_q", bus.q, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised universal shift register that extends the plain right-shift register with left shift, optional rotate, serial in/out on both ends, and a self-timed burst engine that performs N shifts after one `start` pulse. It sits in serializer/deserializer and bit-manipulation datapaths that need a programmed shift count without an external counter.

## Interface
- `DW`, 8: register width; must be ≥ 2.
- `CW`, $clog2(DW)+1: width of `shift_num`.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset; one clock; reset is asynchronous and active-low.
- `sync_rst`, input, 1: synchronous clear; active high.
- `load`, input, 1: parallel load of `data`.
- `data`, input, DW: parallel load value.
- `en`, input, 1: single-step shift in `mode`; used only when the block is idle.
- `mode`, input, 2: shift mode.
  - 00: hold.
  - 01: shift right.
  - 10: shift left.
  - 11: rotate right.
- `ser_in_h`, input, 1: bit entering `q[DW-1]` on a right shift.
- `ser_in_l`, input, 1: bit entering `q[0]` on a left shift.
- `start`, input, 1: begin a burst of `shift_num` shifts in `mode`.
- `shift_num`, input, CW: burst length, 0 to 2^CW−1.
- `q`, output, DW: register contents.
- `ser_out`, output, 1: bit that the next shift will discard.
  - `q[0]` when the effective mode is 01 or 11.
  - `q[DW-1]` when the effective mode is 10.
  - 0 when the effective mode is 00.
- `busy`, output, 1: a burst is in progress.
- `done`, output, 1: one-cycle pulse when a burst completes.

## Operation
- Effective mode:
  - While `busy` is high: the mode captured at `start` (`mode_r`).
  - Otherwise: the `mode` input.
- Priority per edge, highest first: `sync_rst`, `load`, burst step, `start`, `en` step.
- `sync_rst`: q=0, busy=0, done=0, counter=0. An active burst is aborted with no `done`.
- `load`: q=data. An active burst is aborted: busy=0 and no `done`. A `start` in the same cycle is ignored.
- Shift right: q={ser_in_h, q[DW-1:1]}.
- Shift left: q={q[DW-2:0], ser_in_l}.
- Rotate right: q={q[0], q[DW-1:1]}.
- States:
  - IDLE (busy=0).
  - RUN (busy=1).
- IDLE with `start`=1 and `shift_num`=N>0: capture mode_r=mode and cnt=N; go to RUN. No shift occurs on this edge.
- IDLE with `start`=1 and N=0: stay IDLE, q unchanged; `done` pulses the next cycle.
- IDLE with `start`=0 and `en`=1: one shift in `mode`.
- RUN: one shift per edge in mode_r, cnt−1. When cnt reaches 0, go to IDLE and pulse `done`.
- RUN ignores `start`, `en` and `mode` changes.
- Serial inputs are sampled on every shift edge, so a burst can stream `ser_in_h`/`ser_in_l` bits in.
- Burst lengths greater than DW are legal. Shifts continue, filling q with serial-in bits, or wrapping for rotate.

## Timing
- Reset values: q=0, ser_out=0 (effective mode hold or q=0), busy=0, done=0, mode_r=00, cnt=0.
- `rst_n` low clears all state immediately, independent of `clk`. Release is synchronised by the system.
- `load`, `en` and `sync_rst` take effect at the sampling edge; q is visible in the following cycle.
- Burst timing, with `start` sampled at edge E0:
  - busy is high from after E0 through EN.
  - Shifts occur at edges E1..EN.
  - busy is low and done=1 in the cycle after EN.
  - The next `start` is accepted at EN+1.
- `done` is registered and high for exactly one cycle. It never asserts on an abort.
- `ser_out` is combinational from q and the effective mode; it has no added latency.

## Configuration
- `USR_ROTATE_EN` defined: mode 11 performs rotate right, both for `en` steps and for bursts.
- `USR_ROTATE_EN` not defined:
  - Mode 11 acts as hold: q is unchanged.
  - A burst in mode 11 still counts, asserts busy and pulses `done`.
  - `ser_out`=0 in mode 11.

## Test plan
- Reset, DW=8: drive `rst_n` low mid-cycle with q=0x5A → q=0x00, busy=0, done=0 immediately, with no clock edge needed.
- Single step: load 0xA5; then mode=01, en=1, ser_in_h=1 for one edge → ser_out=1 before the edge, q=0xD2 after.
- Left burst: load 0x81; start, shift_num=3, mode=10, ser_in_l=0 → busy high for 3 cycles, q=0x02, 0x04, 0x08, done=1 in the 4th cycle.
- Rotate with `USR_ROTATE_EN`: load 0x01; start, shift_num=8, mode=11 → q=0x80 after E1, q=0x01 after E8, done then. Without the macro, q stays 0x01 and done still pulses after E8.
- Abort: start shift_num=5 mode=01; assert sync_rst at E2 → q=0, busy=0, no done. Repeat with load=1, data=0x3C at E2 → q=0x3C, no done. A `start` issued during RUN is ignored.
- Zero burst: start with shift_num=0 and q=0x77 → busy stays 0, done=1 for one cycle after E0, q=0x77.
